// File: rtl/aes_pkg.sv
// Shared AES constants used by the core wrapper and its companions.
package aes_pkg;
  localparam int AES_BLOCK_W    = 128;
  localparam int AES128_LATENCY = 21;
endpackage

// File: rtl/aes_result_fifo.sv
// Result FIFO: wrapping pointers, occupancy count, combinational head read.
module aes_result_fifo #(
  parameter int W     = 136,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(wr_en && full));
  end
endmodule

// File: rtl/aes_result_buffer.sv
// Tracks live slots of the fixed-latency AES core, captures results with tags
// and hands them out in order; credits keep the FIFO from ever overflowing.
module aes_result_buffer
  import aes_pkg::*;
#(
  parameter int LATENCY = AES128_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] core_state_out,
  output logic                   out_valid,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  input  logic                   out_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = AES_BLOCK_W + TAG_W;

  logic                          in_fire, out_fire;
  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;
  logic [CW-1:0]                 credits;
  logic                          fifo_empty;
  logic [FW-1:0]                 head;

  assign in_ready  = (credits < CW'(DEPTH));
  assign in_fire   = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign out_fire  = out_valid & out_ready;
  assign {out_data, out_tag} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= in_fire;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Tags only matter alongside a set valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_pipe[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credits <= '0;
    else begin
      case ({in_fire, out_fire})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(out_fire && !in_fire && credits == '0));
      assert (!(in_fire && !out_fire && credits == CW'(DEPTH)));
    end
  end

  aes_result_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_pipe[LATENCY-1]),
    .wr_data ({core_state_out, tag_pipe[LATENCY-1]}),
    .rd_en   (out_fire),
    .rd_data (head),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_aes_result_buffer.sv
// Bench for aes_result_buffer: queue-based model of issue/capture/drain plus
// directed scenarios with literal expectations.
module tb_aes_result_buffer;
  localparam int LATENCY = 21;
  localparam int DEPTH   = 4;
  localparam logic [127:0] LIT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, in_ready;
  logic [7:0]   in_tag = 0;
  logic [127:0] core_state_out = 0;
  logic         out_valid, out_ready = 0;
  logic [127:0] out_data;
  logic [7:0]   out_tag;

  aes_result_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_tag(in_tag),
    .in_ready(in_ready), .core_state_out(core_state_out),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] tag; int due; } pend_t;
  typedef struct { logic [127:0] d; logic [7:0] t; } res_t;
  pend_t      pend[$];
  res_t       expq[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         errors = 0, checks = 0, cycle = 0, fires = 0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", n, cycle, a, e);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: compare at negedge, advance model at posedge, return #1 later.
  task automatic tick();
    bit ifire, ofire, exp_ready;
    int inflight;
    @(negedge clk);
    inflight  = pend.size() + expq.size();
    exp_ready = inflight < DEPTH;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, expq.size() != 0);
    chk("credits", dut.credits, inflight);
    chk("credit_bound", inflight <= DEPTH, 1);
    if (expq.size() != 0) begin
      chk("out_data", out_data, expq[0].d);
      chk("out_tag", out_tag, expq[0].t);
    end
    ifire = in_valid && exp_ready;
    ofire = out_ready && expq.size() != 0;
    @(posedge clk);
    if (rst_n) begin
      if (ofire) begin
        got.push_back(expq[0].t);
        got_cyc.push_back(cycle);
        void'(expq.pop_front());
      end
      if (pend.size() != 0 && pend[0].due == cycle) begin
        expq.push_back('{core_state_out, pend[0].tag});
        void'(pend.pop_front());
      end
      if (ifire) begin
        pend.push_back('{in_tag, cycle + LATENCY});
        fires++;
      end
    end
    cycle++;
    #1;
  endtask

  initial begin
    int f0, nt;
    bit bv [6];
    logic [7:0] bt [6];
    bv = '{1, 0, 1, 0, 0, 1};
    bt = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h00, 8'h12};

    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) tick();
    rst_n = 1;
    repeat (2) tick();

    // Single block with the known ciphertext.
    out_ready = 1;
    for (int i = 0; i < 25; i++) begin
      in_valid = (i == 0); in_tag = 8'h05;
      core_state_out = (i == LATENCY) ? LIT : rnd128();
      tick();
      if (i + 1 >= 21 && i + 1 <= 23) chk("single_vld", out_valid, (i + 1) == 22);
      if (i + 1 == 22) begin
        chk("single_data", out_data, LIT);
        chk("single_tag", out_tag, 8'h05);
      end
    end

    // Backpressure: only DEPTH blocks may be in flight.
    out_ready = 0; in_valid = 1; nt = 1; f0 = fires;
    for (int i = 0; i < 30; i++) begin
      in_tag = nt[7:0]; core_state_out = rnd128();
      tick();
      if (fires != f0 + nt - 1) nt++;
    end
    chk("bp_fires", fires - f0, 4);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 0; out_ready = 1; got.delete();
    tick();
    chk("bp_ready_after_pop", in_ready, 1);
    repeat (6) tick();
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_order", got[i], i + 1);

    // Capture and pop in the same cycle with 3 entries stored.
    out_ready = 0; got.delete();
    for (int j = 0; j < 30; j++) begin
      in_valid = (j < 3); in_tag = 8'h20 + j[7:0]; core_state_out = rnd128();
      tick();
    end
    for (int k = 0; k < 23; k++) begin
      in_valid = (k == 0); in_tag = 8'h23; out_ready = (k == LATENCY);
      core_state_out = rnd128();
      tick();
    end
    out_ready = 0; in_valid = 0;
    chk("simul_occupancy", dut.u_fifo.count, 3);
    chk("simul_model_occ", expq.size(), 3);
    out_ready = 1;
    repeat (5) tick();
    chk("simul_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("simul_order", got[i], 8'h20 + i);

    // Bubbles in the issue stream show up as matching gaps in the output.
    got.delete(); got_cyc.delete(); out_ready = 1;
    for (int i = 0; i < 30; i++) begin
      in_valid = (i < 6) ? bv[i] : 1'b0; in_tag = (i < 6) ? bt[i] : 8'h00;
      core_state_out = rnd128();
      tick();
    end
    chk("bubble_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bubble_t0", got[0], 8'h10);
      chk("bubble_t1", got[1], 8'h11);
      chk("bubble_t2", got[2], 8'h12);
      chk("bubble_gap1", got_cyc[1] - got_cyc[0], 2);
      chk("bubble_gap2", got_cyc[2] - got_cyc[1], 3);
    end

    // Reset mid-flight discards everything in the pipe.
    got.delete(); out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 3); in_tag = 8'h30 + i[7:0]; core_state_out = rnd128();
      tick();
    end
    in_valid = 0; rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    pend.delete(); expq.delete();
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 25; i++) begin core_state_out = rnd128(); tick(); end
    chk("rst_no_output", got.size(), 0);

    // Wrap-around with toggling consumer.
    got.delete(); nt = 0; f0 = fires;
    for (int i = 0; i < 400 && got.size() < 20; i++) begin
      in_valid = (nt < 20) && ($urandom_range(3) != 0);
      in_tag = 8'h40 + nt[7:0];
      out_ready = ((i / 3) % 2) == 0;
      core_state_out = rnd128();
      tick();
      nt = fires - f0;
    end
    chk("wrap_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_order", got[i], 8'h40 + i);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(1); in_tag = 8'($urandom);
      out_ready = $urandom_range(2) != 0;
      core_state_out = rnd128();
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (30) tick();
    chk("drained", expq.size() + pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
